// File: rtl/dso_clk_pkg.sv
// dso_clk_pkg: shared state encoding and widths for the DSO clock sequencer.
package dso_clk_pkg;

  localparam int DSO_NUM_DOMAINS = 4;
  localparam int DSO_RELOCK_W    = 8;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } dso_state_e;

  function automatic logic [DSO_RELOCK_W-1:0] sat_inc(
    input logic [DSO_RELOCK_W-1:0] v
  );
    return (&v) ? v : v + DSO_RELOCK_W'(1);
  endfunction

endpackage

// File: rtl/dso_sync2.sv
// dso_sync2: two-flop single-bit synchroniser, synchronous reset to 0.
module dso_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/dso_clk_sequencer.sv
// dso_clk_sequencer: PLL bring-up, staged domain release and sample divider.
// Lock-timeout watchdog and FAULT state built only with DSO_LOCK_WATCHDOG_EN.
module dso_clk_sequencer
  import dso_clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_STABLE    = 256,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int DIV_W          = 16
) (
  input  logic                       inclk0,
  input  logic                       areset,
  input  logic                       pll_locked,
  input  logic [DIV_W-1:0]           rate_div,
  input  logic                       rate_load,
  output logic                       pll_areset,
  output logic [DSO_NUM_DOMAINS-1:0] domain_rst,
  output logic                       sample_en,
  output logic                       ready,
  output logic                       fault,
  output logic [DSO_RELOCK_W-1:0]    relock_cnt,
  output logic [2:0]                 state
);

  localparam int CNT_M0 =
    (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
  localparam int CNT_MAX =
    (CNT_M0 > DSO_NUM_DOMAINS) ? CNT_M0 : DSO_NUM_DOMAINS;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(DSO_NUM_DOMAINS - 1);

  logic lock_s;

  dso_sync2 u_lock_sync (
    .clk_i (inclk0),
    .rst_i (areset),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  dso_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DSO_RELOCK_W-1:0] relock_q, relock_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic pll_areset_q, pll_areset_d;
  logic [DSO_NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic sample_en_q, sample_en_d;
  logic ready_q, ready_d;
  logic lost;
  logic tmo_hit;

`ifdef DSO_LOCK_WATCHDOG_EN
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic fault_q, fault_d;

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Counts consecutive WAIT_LOCK cycles; any other state restarts it.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK)
      tmo_d = tmo_q + TMO_W'(1);
  end

  assign fault_d = (state_d == ST_FAULT);

  always_ff @(posedge inclk0) begin
    if (areset) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign tmo_hit = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_q;
    lost     = 1'b0;
    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s)       state_d = ST_STABLE;
        else if (tmo_hit) state_d = ST_FAULT;
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (cnt_q == REL_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) lost = 1'b1;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase
    if (lost) begin
      state_d  = ST_RESET_PLL;
      cnt_d    = '0;
      relock_d = sat_inc(relock_q);
    end
  end

  // A load in the wrap cycle already feeds the period that starts there.
  always_comb begin
    shadow_d    = rate_load ? rate_div : shadow_q;
    active_d    = active_q;
    div_cnt_d   = '0;
    sample_en_d = 1'b0;
    if (state_d == ST_RUN) begin
      if (state_q != ST_RUN) begin
        active_d = shadow_d;
      end else if (div_cnt_q == active_q) begin
        active_d = shadow_d;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      sample_en_d = (div_cnt_d == active_d);
    end
  end

  always_comb begin
    pll_areset_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    ready_d      = (state_d == ST_RUN);
    domain_rst_d = '1;
    unique case (state_d)
      ST_RELEASE: domain_rst_d = {DSO_NUM_DOMAINS{1'b1}} >> (cnt_d + CNT_W'(1));
      ST_RUN:     domain_rst_d = '0;
      default:    domain_rst_d = '1;
    endcase
  end

  always_ff @(posedge inclk0) begin
    if (areset) begin
      state_q      <= ST_RESET_PLL;
      cnt_q        <= '0;
      relock_q     <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      div_cnt_q    <= '0;
      pll_areset_q <= 1'b1;
      domain_rst_q <= '1;
      sample_en_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      relock_q     <= relock_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      div_cnt_q    <= div_cnt_d;
      pll_areset_q <= pll_areset_d;
      domain_rst_q <= domain_rst_d;
      sample_en_q  <= sample_en_d;
      ready_q      <= ready_d;
    end
  end

  assign pll_areset = pll_areset_q;
  assign domain_rst = domain_rst_q;
  assign sample_en  = sample_en_q;
  assign ready      = ready_q;
  assign relock_cnt = relock_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dso_clk_sequencer.sv
// tb_dso_clk_sequencer: directed and random checks against a behavioural model.
module tb_dso_clk_sequencer;
  import dso_clk_pkg::*;

  localparam int P_RST = 4;
  localparam int P_STB = 8;
  localparam int P_TMO = 100;
`ifdef DSO_LOCK_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic areset, pll_locked, rate_load;
  logic [15:0] rate_div;
  logic pll_areset, sample_en, ready, fault;
  logic [3:0] domain_rst;
  logic [7:0] relock_cnt;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dso_clk_sequencer #(
    .PLL_RST_CYCLES(P_RST), .LOCK_STABLE(P_STB),
    .LOCK_TIMEOUT(P_TMO), .DIV_W(16)
  ) dut (
    .inclk0(clk), .areset(areset), .pll_locked(pll_locked),
    .rate_div(rate_div), .rate_load(rate_load),
    .pll_areset(pll_areset), .domain_rst(domain_rst),
    .sample_en(sample_en), .ready(ready), .fault(fault),
    .relock_cnt(relock_cnt), .state(state)
  );

  dso_state_e m_ph = ST_RESET_PLL;
  int m_t, m_tmo, m_rel, m_shadow, m_period, m_pos;
  bit m_s1, m_s2;

  task automatic m_step(input bit rst, input bit lk, input int rd, input bit ld);
    bit ls, lost;
    int eff;
    if (rst) begin
      m_ph = ST_RESET_PLL; m_t = 0; m_tmo = 0; m_rel = 0;
      m_shadow = 0; m_period = 0; m_pos = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    ls = m_s2; m_s2 = m_s1; m_s1 = lk;
    eff = ld ? rd : m_shadow;
    if (ld) m_shadow = rd;
    lost = 0;
    case (m_ph)
      ST_RESET_PLL: begin
        m_t++;
        if (m_t == P_RST) begin m_ph = ST_WAIT_LOCK; m_t = 0; m_tmo = 0; end
      end
      ST_WAIT_LOCK: begin
        if (ls) begin m_ph = ST_STABLE; m_t = 0; end
        else if (WD) begin
          m_tmo++;
          if (m_tmo == P_TMO) m_ph = ST_FAULT;
        end
      end
      ST_STABLE: begin
        if (!ls) begin m_ph = ST_WAIT_LOCK; m_tmo = 0; end
        else begin
          m_t++;
          if (m_t == P_STB) begin m_ph = ST_RELEASE; m_t = 0; end
        end
      end
      ST_RELEASE: begin
        if (!ls) lost = 1;
        else if (m_t == 3) begin m_ph = ST_RUN; m_period = eff; m_pos = 0; end
        else m_t++;
      end
      ST_RUN: begin
        if (!ls) lost = 1;
        else if (m_pos == m_period) begin m_pos = 0; m_period = eff; end
        else m_pos++;
      end
      default: ;
    endcase
    if (lost) begin
      m_ph = ST_RESET_PLL; m_t = 0;
      if (m_rel < 255) m_rel++;
    end
  endtask

  function automatic logic [18:0] exp_vec();
    logic pa, se, rd, ft;
    logic [3:0] dr;
    pa = (m_ph == ST_RESET_PLL) || (m_ph == ST_FAULT);
    rd = (m_ph == ST_RUN);
    ft = (m_ph == ST_FAULT);
    se = rd && (m_pos == m_period);
    if (m_ph == ST_RELEASE) dr = 4'hF >> (m_t + 1);
    else if (m_ph == ST_RUN) dr = 4'h0;
    else dr = 4'hF;
    return {pa, dr, se, rd, ft, 8'(m_rel), 3'(m_ph)};
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_step(areset, pll_locked, int'(rate_div), rate_load);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [18:0] got, want;
      got = {pll_areset, domain_rst, sample_en, ready, fault, relock_cnt, state};
      want = exp_vec();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL model cyc=%0d {pa,rst,se,rdy,flt,rel,st} got=%h want=%h",
                 cyc, got, want);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      tick(1);
      if (ready === 1'b1) begin c = cyc; break; end
    end
    if (c < 0) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_pulse(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (sample_en === 1'b1) begin c = cyc; break; end
    end
    if (c < 0) chk("pulse_timeout", 0, 1);
  endtask

  initial begin
    int pa_cnt, c, x, p0, p1, p2, p3, p4, p5;
    logic [3:0] seq[$];
    areset = 1; pll_locked = 1; rate_load = 0; rate_div = 0;
    tick(1);
    chk_en = 1;
    chk("rst_state", int'(state), int'(ST_RESET_PLL));
    chk("rst_pll_areset", int'(pll_areset), 1);
    chk("rst_domain", int'(domain_rst), 15);
    chk("rst_ready_fault_se", int'({ready, fault, sample_en}), 0);
    chk("rst_relock", int'(relock_cnt), 0);
    areset = 0;

    pa_cnt = int'(pll_areset);
    seq.push_back(domain_rst);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      pa_cnt += int'(pll_areset);
      if (domain_rst != seq[$]) seq.push_back(domain_rst);
      if (k == 16) chk("ready_before_run", int'(ready), 0);
      if (k == 17) chk("ready_at_run", int'(ready), 1);
    end
    chk("pll_areset_len", pa_cnt, P_RST);
    chk("release_seq_len", seq.size(), 5);
    if (seq.size() == 5)
      chk("release_seq", int'({seq[0], seq[1], seq[2], seq[3], seq[4]}), 'hF7310);

    rate_div = 3; rate_load = 1; tick(1); rate_load = 0;
    wait_pulse(p0); wait_pulse(p1); wait_pulse(p2);
    chk("div3_gap_a", p1 - p0, 4);
    chk("div3_gap_b", p2 - p1, 4);
    tick(1);
    rate_div = 0; rate_load = 1; tick(1); rate_load = 0;
    wait_pulse(p3); wait_pulse(p4); wait_pulse(p5);
    chk("div0_old_period", p3 - p2, 4);
    chk("div0_gap_a", p4 - p3, 1);
    chk("div0_gap_b", p5 - p4, 1);

    areset = 1; pll_locked = 0; tick(1); areset = 0;
    tick(10);
    pll_locked = 1;
    c = -1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (state === 3'(ST_STABLE)) begin c = cyc; break; end
    end
    if (c < 0) chk("stable_timeout", 0, 1);
    tick(3);
    pll_locked = 0; tick(2); pll_locked = 1;
    x = cyc;
    wait_ready(40, c);
    chk("glitch_release_delay", c - x, 15);

    for (int r = 1; r <= 3; r++) begin
      pll_locked = 0;
      c = -1;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (ready === 1'b0) begin c = cyc; break; end
      end
      if (c < 0) chk("drop_timeout", 0, 1);
      chk("relock_domain_rst", int'(domain_rst), 15);
      chk("relock_cnt_step", int'(relock_cnt), r);
      tick(2); pll_locked = 1;
      wait_ready(60, c);
    end
    chk("relock_cnt_3", int'(relock_cnt), 3);

    for (int r = 0; r < 260; r++) begin
      pll_locked = 0; tick(3); pll_locked = 1;
      wait_ready(60, c);
    end
    chk("relock_saturate", int'(relock_cnt), 255);

    areset = 1; pll_locked = 0; tick(1); areset = 0;
    tick(150);
    if (WD) begin
      chk("wd_fault", int'(fault), 1);
      chk("wd_pll_areset", int'(pll_areset), 1);
      chk("wd_state", int'(state), int'(ST_FAULT));
      areset = 1; tick(1); areset = 0;
      chk("wd_cleared", int'(fault), 0);
    end else begin
      chk("nowd_state", int'(state), int'(ST_WAIT_LOCK));
      chk("nowd_fault", int'(fault), 0);
    end

    for (int seg = 0; seg < 400; seg++) begin
      bit v;
      int len;
      v = ($urandom_range(0, 3) != 0);
      if (v) len = $urandom_range(20, 120);
      else if ($urandom_range(0, 19) == 0) len = $urandom_range(100, 140);
      else len = $urandom_range(1, 12);
      pll_locked = v;
      for (int i = 0; i < len; i++) begin
        rate_load = ($urandom_range(0, 7) == 0);
        rate_div = 16'($urandom_range(0, 5));
        areset = ($urandom_range(0, 499) == 0) ||
                 (m_ph == ST_FAULT && $urandom_range(0, 19) == 0);
        tick(1);
      end
    end
    areset = 0; rate_load = 0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
